// File: rtl/alu_if.sv
// Execute-stage ALU bus: the sequencer drives opcode, modifiers and operands;
// the ALU returns the combinational result.
interface alu_if;
  logic [6:0]  opm;
  logic [4:0]  cmd;
  logic [63:0] a;
  logic [63:0] b;
  logic [63:0] out;

  modport master (output opm, output cmd, output a, output b, input out);
  modport slave  (input opm, input cmd, input a, input b, output out);
endinterface

// File: rtl/alu.sv
// FOP64 execute-stage ALU: 64-bit combinational datapath plus clocked flag register.
// Optional multiplier (cmds 20/21) is enabled by defining ALU_MULT_EN.
module alu #(
  parameter int unsigned FLAG_W = 8
) (
  input logic   clk,
  input logic   rst_n,
  alu_if.slave  bus
);

  typedef enum logic [4:0] {
    C_ZERO     = 5'd0,
    C_SIGN     = 5'd1,
    C_PASSFLAG = 5'd2,
    C_LOADFLAG = 5'd3,
    C_INV      = 5'd4,
    C_AND      = 5'd5,
    C_OR       = 5'd6,
    C_XOR      = 5'd7,
    C_ADD      = 5'd8,
    C_SUB      = 5'd9,
    C_NEG      = 5'd10,
    C_SHL      = 5'd11,
    C_SHR      = 5'd12,
    C_MIN      = 5'd13,
    C_MAX      = 5'd14,
    C_PASSA    = 5'd15,
    C_PASSB    = 5'd16,
    C_CMP      = 5'd17,
    C_INC      = 5'd18,
    C_DEC      = 5'd19,
    C_MUL      = 5'd20,
    C_MULH     = 5'd21
  } cmd_e;

  logic [FLAG_W-1:0] flags;
  logic [FLAG_W-1:0] flags_nxt;

  logic [63:0] a;
  logic [63:0] b;
  logic        hold;
  logic        sgn;
  logic        cin;
  logic [5:0]  sh;

  assign a    = bus.a;
  assign b    = bus.b;
  assign hold = bus.opm[0];
  assign sgn  = ~bus.opm[1];
  assign cin  = bus.opm[2] & flags[2];
  assign sh   = b[5:0];

  logic unused;
  assign unused = ^{bus.opm[6:3], b[63:6]};

  logic [64:0]        add_full;
  logic [64:0]        sub_full;
  logic [64:0]        inc_full;
  logic [64:0]        dec_full;
  logic [63:0]        neg_res;
  logic [64:0]        shl_full;
  logic signed [64:0] shr_full;
  logic               add_v;
  logic               sub_v;
  logic               lt;

  assign add_full = {1'b0, a} + {1'b0, b} + {64'd0, cin};
  assign sub_full = {1'b0, a} - {1'b0, b} - {64'd0, cin};
  assign inc_full = {1'b0, a} + 65'd1;
  assign dec_full = {1'b0, a} - 65'd1;
  assign neg_res  = '0 - a;
  assign add_v    = (a[63] == b[63]) & (add_full[63] != a[63]);
  assign sub_v    = (a[63] != b[63]) & (sub_full[63] != a[63]);
  assign lt       = sgn ? ($signed(a) < $signed(b)) : (a < b);

  // One guard bit on the far side of each shift captures the last bit shifted
  // out; with a zero shift amount the guard stays 0.
  assign shl_full = {1'b0, a} << sh;
  assign shr_full = sgn ? ($signed({a, 1'b0}) >>> sh) : $signed({a, 1'b0} >> sh);

`ifdef ALU_MULT_EN
  logic [127:0] prod_s;
  logic [127:0] prod_u;
  logic [127:0] prod;
  logic         mul_ovf;

  assign prod_s  = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
  assign prod_u  = {64'd0, a} * {64'd0, b};
  assign prod    = sgn ? prod_s : prod_u;
  assign mul_ovf = sgn ? ~((&prod[127:63]) | ~(|prod[127:63])) : (|prod[127:64]);
`endif

  logic [63:0] res;
  logic [63:0] fres;
  logic        fc;
  logic        fv;
  logic        upd;
  logic        load;

  always_comb begin
    res  = '0;
    fres = '0;
    fc   = 1'b0;
    fv   = 1'b0;
    upd  = 1'b0;
    load = 1'b0;
    case (cmd_e'(bus.cmd))
      C_ZERO:     res = '0;
      C_SIGN: begin
        if (sgn && b[63]) res = '1;
        else              res = {63'd0, |b};
      end
      C_PASSFLAG: res = {{(64-FLAG_W){1'b0}}, flags};
      C_LOADFLAG: load = 1'b1;
      C_INV:      begin res = ~a;    upd = 1'b1; end
      C_AND:      begin res = a & b; upd = 1'b1; end
      C_OR:       begin res = a | b; upd = 1'b1; end
      C_XOR:      begin res = a ^ b; upd = 1'b1; end
      C_ADD: begin
        res = add_full[63:0]; fc = add_full[64]; fv = add_v; upd = 1'b1;
      end
      C_SUB: begin
        res = sub_full[63:0]; fc = sub_full[64]; fv = sub_v; upd = 1'b1;
      end
      C_NEG: begin
        res = neg_res; fc = |a; fv = a[63] & neg_res[63]; upd = 1'b1;
      end
      C_SHL:      begin res = shl_full[63:0]; fc = shl_full[64]; upd = 1'b1; end
      C_SHR:      begin res = shr_full[64:1]; fc = shr_full[0];  upd = 1'b1; end
      C_MIN:      begin res = lt ? a : b; upd = 1'b1; end
      C_MAX:      begin res = lt ? b : a; upd = 1'b1; end
      C_PASSA:    begin res = a; upd = 1'b1; end
      C_PASSB:    begin res = b; upd = 1'b1; end
      C_CMP: begin
        fres = sub_full[63:0]; fc = sub_full[64]; fv = sub_v; upd = 1'b1;
      end
      C_INC: begin
        res = inc_full[63:0]; fc = inc_full[64];
        fv = ~a[63] & inc_full[63]; upd = 1'b1;
      end
      C_DEC: begin
        res = dec_full[63:0]; fc = dec_full[64];
        fv = a[63] & ~dec_full[63]; upd = 1'b1;
      end
`ifdef ALU_MULT_EN
      C_MUL:      begin res = prod[63:0];   fc = mul_ovf; fv = mul_ovf; upd = 1'b1; end
      C_MULH:     begin res = prod[127:64]; fc = mul_ovf; fv = mul_ovf; upd = 1'b1; end
`endif
      default:    res = '0;
    endcase
    // CMP discards the difference on out but still derives Z/N from it
    if (cmd_e'(bus.cmd) != C_CMP) fres = res;
  end

  assign bus.out = res;

  always_comb begin
    flags_nxt = flags;
    if (load)
      flags_nxt = a[FLAG_W-1:0];
    else if (upd && !hold)
      flags_nxt = {flags[FLAG_W-1:4], fv, fc, fres[63], (fres == 64'd0)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags <= '0;
    else        flags <= flags_nxt;
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: vector table run through an expected-result
// scoreboard, plus hand-written reset and LOADFLAG sequences.
module tb_alu;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  alu_if bus ();

  alu #(.FLAG_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [7:0]  pre;
    logic [4:0]  cmd;
    logic [6:0]  opm;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp_out;
    logic [7:0]  exp_fl;
  } vec_t;

  vec_t        vecs[$];
  logic [63:0] exp_q[$];
  string       name_q[$];

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINS = 64'h8000_0000_0000_0000;
  localparam logic [63:0] MAXS = 64'h7FFF_FFFF_FFFF_FFFF;

  task automatic add_vec(input string n, input logic [7:0] pre, input logic [4:0] cmd,
                         input logic [6:0] opm, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] eo, input logic [7:0] ef);
    vec_t v;
    v.name = n; v.pre = pre; v.cmd = cmd; v.opm = opm;
    v.a = a; v.b = b; v.exp_out = eo; v.exp_fl = ef;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [4:0] cmd, input logic [6:0] opm,
                       input logic [63:0] a, input logic [63:0] b);
    bus.cmd = cmd; bus.opm = opm; bus.a = a; bus.b = b;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Expected value goes on the scoreboard when stimulus is applied; it is
  // popped and compared once out has settled, well before the next posedge.
  task automatic expect_out(input string n, input logic [63:0] e);
    logic [63:0] exp;
    string       nm;
    exp_q.push_back(e);
    name_q.push_back(n);
    #2;
    exp  = exp_q.pop_front();
    nm   = name_q.pop_front();
    checks++;
    if (bus.out !== exp) begin
      failures++;
      $display("FAIL %s: out=%h expected=%h", nm, bus.out, exp);
    end
  endtask

  task automatic load_flags(input logic [7:0] f);
    drive(5'd3, 7'd0, {56'd0, f}, 64'd0);
    tick();
  endtask

  task automatic run_vec(input vec_t v);
    load_flags(v.pre);
    drive(v.cmd, v.opm, v.a, v.b);
    expect_out({v.name, "/out"}, v.exp_out);
    tick();
    drive(5'd2, 7'd0, 64'd0, 64'd0);
    expect_out({v.name, "/flags"}, {56'd0, v.exp_fl});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    add_vec("sign_neg",  8'h00, 5'd1,  7'd0, 64'd0, ONES, ONES, 8'h00);
    add_vec("sign_zero", 8'h00, 5'd1,  7'd0, 64'd0, 64'd0, 64'd0, 8'h00);
    add_vec("sign_pos",  8'h00, 5'd1,  7'd0, 64'd0, 64'd5, 64'd1, 8'h00);
    add_vec("sign_uns",  8'h00, 5'd1,  7'd2, 64'd0, ONES, 64'd1, 8'h00);
    add_vec("inv_z",     8'h00, 5'd4,  7'd0, ONES, 64'd0, 64'd0, 8'h01);
    add_vec("inv_user",  8'hF0, 5'd4,  7'd0, ONES, 64'd0, 64'd0, 8'hF1);
    add_vec("inv_n",     8'h0E, 5'd4,  7'd0, 64'd0, 64'd0, ONES, 8'h02);
    add_vec("and",       8'h0E, 5'd5,  7'd0, 64'hF0F0F0F0F0F0F0F0, 64'hFF00FF00FF00FF00,
            64'hF000F000F000F000, 8'h02);
    add_vec("or",        8'h00, 5'd6,  7'd0, 64'hF0F0F0F0F0F0F0F0, 64'hFF00FF00FF00FF00,
            64'hFFF0FFF0FFF0FFF0, 8'h02);
    add_vec("xor",       8'h00, 5'd7,  7'd0, 64'hF0F0F0F0F0F0F0F0, 64'hFF00FF00FF00FF00,
            64'h0FF00FF00FF00FF0, 8'h00);
    add_vec("add_ovf",   8'h00, 5'd8,  7'd0, MAXS, 64'd1, MINS, 8'h0A);
    add_vec("add_hold",  8'h35, 5'd8,  7'd1, MAXS, 64'd1, MINS, 8'h35);
    add_vec("add_carry", 8'h00, 5'd8,  7'd0, ONES, 64'd1, 64'd0, 8'h05);
    add_vec("add_cin",   8'h04, 5'd8,  7'd4, 64'd5, 64'd6, 64'd12, 8'h00);
    add_vec("add_cin_off", 8'h04, 5'd8, 7'd0, 64'd5, 64'd6, 64'd11, 8'h00);
    add_vec("sub_borrow", 8'h00, 5'd9, 7'd0, 64'd0, 64'd1, ONES, 8'h06);
    add_vec("sub_cin",   8'h04, 5'd9,  7'd4, 64'd10, 64'd3, 64'd6, 8'h00);
    add_vec("sub_ovf",   8'h00, 5'd9,  7'd0, MINS, 64'd1, MAXS, 8'h08);
    add_vec("neg_one",   8'h00, 5'd10, 7'd0, 64'd1, 64'd0, ONES, 8'h06);
    add_vec("neg_zero",  8'h0E, 5'd10, 7'd0, 64'd0, 64'd0, 64'd0, 8'h01);
    add_vec("neg_min",   8'h00, 5'd10, 7'd0, MINS, 64'd0, MINS, 8'h0E);
    add_vec("shl_c",     8'h00, 5'd11, 7'd0, 64'h8000000000000001, 64'd1, 64'd2, 8'h04);
    add_vec("shl_zero",  8'h04, 5'd11, 7'd0, MINS, 64'd0, MINS, 8'h02);
    add_vec("shr_s",     8'h00, 5'd12, 7'd0, MINS, 64'hFFFFFFFFFFFFFFC4,
            64'hF800000000000000, 8'h02);
    add_vec("shr_u",     8'h00, 5'd12, 7'd2, MINS, 64'hFFFFFFFFFFFFFFC4,
            64'h0800000000000000, 8'h00);
    add_vec("shr_c",     8'h00, 5'd12, 7'd2, 64'd6, 64'd2, 64'd1, 8'h04);
    add_vec("shr_63",    8'h00, 5'd12, 7'd0, MINS, 64'd63, ONES, 8'h02);
    add_vec("min_s",     8'h00, 5'd13, 7'd0, ONES, 64'd1, ONES, 8'h02);
    add_vec("min_u",     8'h00, 5'd13, 7'd2, ONES, 64'd1, 64'd1, 8'h00);
    add_vec("max_s",     8'h00, 5'd14, 7'd0, ONES, 64'd1, 64'd1, 8'h00);
    add_vec("max_u",     8'h00, 5'd14, 7'd2, ONES, 64'd1, ONES, 8'h02);
    add_vec("passa",     8'h0E, 5'd15, 7'd0, 64'd0, 64'd9, 64'd0, 8'h01);
    add_vec("passb",     8'h00, 5'd16, 7'd0, 64'd0, 64'd123, 64'd123, 8'h00);
    add_vec("cmp_lt",    8'h00, 5'd17, 7'd0, 64'd3, 64'd5, 64'd0, 8'h06);
    add_vec("cmp_eq",    8'h00, 5'd17, 7'd0, 64'd5, 64'd5, 64'd0, 8'h01);
    add_vec("inc_ovf",   8'h00, 5'd18, 7'd0, MAXS, 64'd0, MINS, 8'h0A);
    add_vec("inc_wrap",  8'h00, 5'd18, 7'd0, ONES, 64'd0, 64'd0, 8'h05);
    add_vec("dec_zero",  8'h00, 5'd19, 7'd0, 64'd0, 64'd0, ONES, 8'h06);
    add_vec("dec_min",   8'h00, 5'd19, 7'd0, MINS, 64'd0, MAXS, 8'h08);
    add_vec("zero",      8'h33, 5'd0,  7'd0, ONES, ONES, 64'd0, 8'h33);
    add_vec("rsv25",     8'h5A, 5'd25, 7'd0, ONES, ONES, 64'd0, 8'h5A);
    add_vec("ldf_hold",  8'h00, 5'd3,  7'd1, 64'hA5, 64'd0, 64'd0, 8'hA5);
`ifdef ALU_MULT_EN
    add_vec("mul_s",     8'h00, 5'd20, 7'd0, 64'd3, ONES - 64'd1, ONES - 64'd5, 8'h02);
    add_vec("mulh_s",    8'h00, 5'd21, 7'd0, 64'd3, ONES - 64'd1, ONES, 8'h02);
    add_vec("mulh_u",    8'h00, 5'd21, 7'd2, ONES, 64'd2, 64'd1, 8'h0C);
`else
    add_vec("rsv20",     8'h5A, 5'd20, 7'd0, 64'd3, 64'd4, 64'd0, 8'h5A);
    add_vec("rsv21",     8'h5A, 5'd21, 7'd0, 64'd3, 64'd4, 64'd0, 8'h5A);
`endif

    // Reset: flags cleared, out still combinational from cmd
    rst_n = 1'b0;
    drive(5'd2, 7'd0, 64'd0, 64'd0);
    expect_out("rst_passflag", 64'd0);
    tick();
    rst_n = 1'b1;
    drive(5'd0, 7'd0, ONES, ONES);
    expect_out("rst_zero", 64'd0);
    tick();

    // LOADFLAG: out stays 0 while loading, flags visible after the edge
    drive(5'd3, 7'd0, ONES, 64'd0);
    expect_out("ldf_out", 64'd0);
    tick();
    drive(5'd2, 7'd0, 64'd0, 64'd0);
    expect_out("ldf_ff", 64'hFF);
    tick();
    drive(5'd3, 7'd0, 64'd0, 64'd0);
    tick();
    drive(5'd2, 7'd0, 64'd0, 64'd0);
    expect_out("ldf_00", 64'd0);
    tick();

    // Async reset mid-cycle clears flags without waiting for an edge
    load_flags(8'hC3);
    drive(5'd2, 7'd0, 64'd0, 64'd0);
    expect_out("pre_async", 64'hC3);
    rst_n = 1'b0;
    expect_out("async_clear", 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Back-to-back flag producers: second sees carry from the first
    load_flags(8'h00);
    drive(5'd8, 7'd0, ONES, 64'd1);
    tick();
    drive(5'd8, 7'd4, 64'd1, 64'd1);
    expect_out("chain_cin", 64'd3);
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
